execute_unit: RTL and testbench
===============================

Name: execute_unit

Overview:
- Execute stage directly downstream of register_file.
- Consumes the two read operands (data1, data2) with an opcode and destination register.
- Computes single-cycle ALU ops and a 16-cycle iterative multiply.
- Drives the register_file write port (write, write_data, destination select) with a one-cycle writeback pulse, plus zero/carry flags.

Parameters:
- DATA_W, 16: operand/result width; must match register_file data width.
- REG_ADDR_W, 2: destination register index width (4 registers).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset; asserting it (low) immediately clears all state.
- in_valid  input  1  operation request valid.
- in_ready  output  1  unit can accept; equals (state == IDLE).
- op  input  3  opcode (see Behaviour).
- dest  input  REG_ADDR_W  destination register index.
- data1  input  DATA_W  operand A (register_file data1).
- data2  input  DATA_W  operand B (register_file data2).
- wb_write  output  1  one-cycle writeback strobe to register_file write.
- wb_dest  output  REG_ADDR_W  writeback register index.
- wb_data  output  DATA_W  writeback value to register_file write_data.
- zero_flag  output  1  wb_data == 0, registered with each writeback.
- carry_flag  output  1  ADD carry-out / SUB borrow; 0 for all other ops.
- busy  output  1  high while state == MUL.

Behaviour:
- Reset values (while reset low): wb_write=0, wb_dest=0, wb_data=0, zero_flag=0, carry_flag=0, busy=0, state=IDLE, iteration counter=0. in_ready reads 1 but inputs are ignored during reset.
- Accept rule: an op is accepted on a rising edge where in_valid && in_ready. Operands, op and dest are sampled only on that edge and need not be held afterwards.
- Opcodes:
  - 000 ADD: data1+data2, carry = bit 16 of the 17-bit sum.
  - 001 SUB: data1-data2, carry = borrow (data1 < data2, unsigned).
  - 010 AND, 011 OR, 100 XOR.
  - 101 SHL: data1 << data2[3:0]; 110 SHR (logical): data1 >> data2[3:0]. Upper bits of data2 are ignored.
  - 111 MUL: low DATA_W bits of the unsigned product; carry=0.
- Single-cycle ops (000–110):
  - Result, flags, wb_dest and wb_write=1 are registered on the accept edge, so wb_write is high the cycle after accept (latency 1).
  - State stays IDLE, so back-to-back accepts give consecutive wb_write pulses.
- MUL state machine (IDLE -> MUL -> IDLE):
  - On accept: latch mcand=data1, mplier=data2, acc=0, cnt=0, dest; go to MUL. wb_write=0 on that edge.
  - Each MUL edge: if mplier[0] then acc += mcand (mod 2^DATA_W); mcand <<= 1; mplier >>= 1; cnt++.
  - On the 16th MUL edge (cnt==DATA_W-1 before increment): wb_data=final acc, wb_write=1, flags updated, state returns to IDLE.
  - Accept at edge e0 -> wb_write high after edge e16 (latency 17). in_ready is low for 16 cycles.
- wb_write is a single-cycle pulse: cleared on any edge that produces no result. wb_dest/wb_data hold their last value when wb_write=0.
- zero_flag/carry_flag update only on writeback edges and otherwise hold.
- in_valid asserted while in_ready=0 is ignored, with no queueing.
- Reset asserted mid-MUL aborts immediately: no writeback ever issues for the aborted op. After release the unit is IDLE with in_ready=1.
- dest=0 is legal; the register file has no hardwired-zero register.

Decomposition:
- tinychip_pkg holds:
  - op_e enum: OP_ADD..OP_MUL with the encodings above.
  - DATA_W and REG_ADDR_W constants.
  - exec_state_e enum: IDLE, MUL.
- One sub-module: seq_multiplier. It holds the shift-add datapath and counter, with a start/done handshake (done is a one-cycle pulse with product). execute_unit instantiates it and muxes its result into the writeback register.

Test Plan:
- Reset low 2 cycles then release; ADD data1=16'hABCD data2=16'h0001 dest=2 -> next cycle wb_write=1, wb_dest=2, wb_data=16'hABCE, zero=0, carry=0.
- ADD 16'hFFFF+16'h0001 dest=1 -> wb_data=16'h0000, zero=1, carry=1. Then SUB 16'h0003-16'h0005 -> 16'hFFFE, carry=1.
- Back-to-back XOR 16'hABCD^16'hABCD, then SHL data1=16'h0001 data2=16'h0013 -> wb_write high two consecutive cycles with 16'h0000 (zero=1) then 16'h0008.
- MUL 16'h0123*16'h0010 dest=3 with in_valid held high throughout:
  - in_ready=0 and busy=1 for exactly 16 cycles.
  - wb_write pulses once, 17 edges after accept, with wb_data=16'h1230, wb_dest=3.
  - A new op is accepted only after that pulse.
- MUL 16'hFFFF*16'hFFFF -> wb_data=16'h0001, carry=0, zero=0.
- Reset asserted after 8 MUL iterations -> outputs immediately 0, no wb_write pulse ever seen. After release in_ready=1, and ADD 16'h0002+16'h0003 -> 16'h0005 with latency 1.

Source files
------------

// File: rtl/tinychip_pkg.sv
// Shared widths, opcode encodings and execute-stage state type for the tinychip datapath.
package tinychip_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 2;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } exec_state_e;

endpackage

// File: rtl/execute_unit_seq_multiplier.sv
// Shift-add unsigned multiplier, one multiplier bit per cycle, low DATA_W product bits.
module seq_multiplier
  import tinychip_pkg::*;
#(
  parameter int DATA_W = tinychip_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_next;
  logic [CNT_W-1:0]  cnt;
  logic              running;

  assign acc_next = mplier[0] ? acc + mcand : acc;

  // done/product are combinational so the caller can register the result on the final iteration edge
  assign done    = running && (cnt == CNT_W'(DATA_W - 1));
  assign product = acc_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      mcand   <= a;
      mplier  <= b;
      acc     <= '0;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (done) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/execute_unit.sv
// Execute stage: single-cycle ALU ops plus iterative multiply, driving register_file writeback.
module execute_unit
  import tinychip_pkg::*;
#(
  parameter int DATA_W     = tinychip_pkg::DATA_W,
  parameter int REG_ADDR_W = tinychip_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [REG_ADDR_W-1:0] dest,
  input  logic [DATA_W-1:0]     data1,
  input  logic [DATA_W-1:0]     data2,
  output logic                  wb_write,
  output logic [REG_ADDR_W-1:0] wb_dest,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  zero_flag,
  output logic                  carry_flag,
  output logic                  busy
);

  localparam int SH_W = $clog2(DATA_W);

  exec_state_e           state;
  op_e                   op_q;
  logic                  accept;
  logic                  mul_start;
  logic                  mul_done;
  logic [DATA_W-1:0]     mul_product;
  logic [REG_ADDR_W-1:0] pend_dest;
  logic [DATA_W:0]       sum;
  logic [DATA_W-1:0]     alu_res;
  logic                  alu_carry;

  assign op_q      = op_e'(op);
  assign in_ready  = (state == IDLE);
  assign busy      = (state == MUL);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op_q == OP_MUL);

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    sum       = {1'b0, data1} + {1'b0, data2};
    case (op_q)
      OP_ADD: begin
        alu_res   = sum[DATA_W-1:0];
        alu_carry = sum[DATA_W];
      end
      OP_SUB: begin
        alu_res   = data1 - data2;
        alu_carry = (data1 < data2);
      end
      OP_AND:  alu_res = data1 & data2;
      OP_OR:   alu_res = data1 | data2;
      OP_XOR:  alu_res = data1 ^ data2;
      OP_SHL:  alu_res = data1 << data2[SH_W-1:0];
      OP_SHR:  alu_res = data1 >> data2[SH_W-1:0];
      OP_MUL:  alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  seq_multiplier #(
    .DATA_W(DATA_W)
  ) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (mul_start),
    .a      (data1),
    .b      (data2),
    .done   (mul_done),
    .product(mul_product)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pend_dest  <= '0;
      wb_write   <= 1'b0;
      wb_dest    <= '0;
      wb_data    <= '0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else begin
      wb_write <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (op_q == OP_MUL) begin
              pend_dest <= dest;
              state     <= MUL;
            end else begin
              wb_write   <= 1'b1;
              wb_dest    <= dest;
              wb_data    <= alu_res;
              zero_flag  <= (alu_res == '0);
              carry_flag <= alu_carry;
            end
          end
        end
        MUL: begin
          if (mul_done) begin
            wb_write   <= 1'b1;
            wb_dest    <= pend_dest;
            wb_data    <= mul_product;
            zero_flag  <= (mul_product == '0);
            carry_flag <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_unit.sv
// Directed plus randomized bench for execute_unit against an arithmetic reference model.
module tb_execute_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [1:0]  dest;
  logic [15:0] data1;
  logic [15:0] data2;
  logic        wb_write;
  logic [1:0]  wb_dest;
  logic [15:0] wb_data;
  logic        zero_flag;
  logic        carry_flag;
  logic        busy;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  execute_unit #(
    .DATA_W(16),
    .REG_ADDR_W(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .dest      (dest),
    .data1     (data1),
    .data2     (data2),
    .wb_write  (wb_write),
    .wb_dest   (wb_dest),
    .wb_data   (wb_data),
    .zero_flag (zero_flag),
    .carry_flag(carry_flag),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference semantics straight from the opcode table, using wide integer arithmetic.
  function automatic void ref_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] r, output logic c);
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint unsigned p;
    c = 1'b0;
    case (o)
      3'd0: begin p = ua + ub; r = p[15:0]; c = p[16]; end
      3'd1: begin r = a - b; c = (ua < ub); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << b[3:0];
      3'd6: r = a >> b[3:0];
      default: begin p = ua * ub; r = p[15:0]; end
    endcase
  endfunction

  task automatic do_single(input string tag, input logic [2:0] o, input logic [15:0] a,
                           input logic [15:0] b, input logic [1:0] d);
    logic [15:0] r;
    logic        c;
    ref_op(o, a, b, r, c);
    @(negedge clk);
    chk({tag, "_ready"}, in_ready, 1);
    in_valid = 1'b1; op = o; data1 = a; data2 = b; dest = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data1 = $urandom; data2 = $urandom;
    chk({tag, "_wb_write"}, wb_write, 1);
    chk({tag, "_wb_dest"},  wb_dest, d);
    chk({tag, "_wb_data"},  wb_data, r);
    chk({tag, "_zero"},     zero_flag, (r == 16'h0));
    chk({tag, "_carry"},    carry_flag, c);
  endtask

  task automatic do_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] d, input bit hold);
    logic [15:0] r;
    logic        c;
    int unsigned busy_cnt;
    int unsigned n;
    bit          seen;
    ref_op(3'd7, a, b, r, c);
    @(negedge clk);
    chk({tag, "_ready"}, in_ready, 1);
    in_valid = 1'b1; op = 3'd7; data1 = a; data2 = b; dest = d;
    @(posedge clk);
    #1;
    if (!hold) begin
      in_valid = 1'b0;
      data1 = $urandom; data2 = $urandom;
    end
    busy_cnt = 0; n = 0; seen = 0;
    while (!seen && n < 40) begin
      if (wb_write) begin
        seen = 1;
      end else begin
        if (busy && !in_ready) busy_cnt++;
        @(posedge clk);
        #1;
        n++;
      end
    end
    chk({tag, "_pulse_seen"}, seen, 1);
    chk({tag, "_latency"},    n, 16);
    chk({tag, "_busy_cycles"}, busy_cnt, 16);
    chk({tag, "_wb_dest"},    wb_dest, d);
    chk({tag, "_wb_data"},    wb_data, r);
    chk({tag, "_zero"},       zero_flag, (r == 16'h0));
    chk({tag, "_carry"},      carry_flag, 0);
    chk({tag, "_ready_after"}, in_ready, 1);
  endtask

  initial begin
    logic [15:0] held;
    int unsigned pulses;
    logic [2:0]  ro;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [1:0]  rd;

    reset = 1'b0; in_valid = 1'b1; op = 3'd0; dest = 2'd1;
    data1 = 16'h1111; data2 = 16'h2222;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_write", wb_write, 0);
    chk("rst_wb_dest",  wb_dest, 0);
    chk("rst_wb_data",  wb_data, 0);
    chk("rst_zero",     zero_flag, 0);
    chk("rst_carry",    carry_flag, 0);
    chk("rst_busy",     busy, 0);
    chk("rst_ready",    in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;

    do_single("add1", 3'd0, 16'hABCD, 16'h0001, 2'd2);
    @(posedge clk);
    #1;
    chk("add1_pulse_drop", wb_write, 0);
    chk("add1_data_hold",  wb_data, 16'hABCE);
    do_single("add_ovf", 3'd0, 16'hFFFF, 16'h0001, 2'd1);
    do_single("sub_borrow", 3'd1, 16'h0003, 16'h0005, 2'd0);
    do_single("xor_b2b", 3'd4, 16'hABCD, 16'hABCD, 2'd3);
    do_single("shl_b2b", 3'd5, 16'h0001, 16'h0013, 2'd2);

    do_mul("mul_hold", 16'h0123, 16'h0010, 2'd3, 1'b1);
    op = 3'd0; data1 = 16'h0007; data2 = 16'h0009; dest = 2'd0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("post_mul_wb_write", wb_write, 1);
    chk("post_mul_wb_data",  wb_data, 16'h0010);
    chk("post_mul_wb_dest",  wb_dest, 0);

    do_mul("mul_ffff", 16'hFFFF, 16'hFFFF, 2'd1, 1'b0);
    held = wb_data;
    @(posedge clk);
    #1;
    chk("mul_pulse_drop", wb_write, 0);
    chk("mul_data_hold",  wb_data, held);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = 16'($urandom);
      rb = 16'($urandom);
      rd = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) ra = 16'h0000;
      if (ro == 3'd7) do_mul("rnd_mul", ra, rb, rd, 1'b0);
      else            do_single("rnd_alu", ro, ra, rb, rd);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Abort a multiply halfway through with an asynchronous reset.
    @(negedge clk);
    in_valid = 1'b1; op = 3'd7; data1 = 16'h00FF; data2 = 16'h0101; dest = 2'd2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_wb_write", wb_write, 0);
    chk("abort_wb_data",  wb_data, 0);
    chk("abort_wb_dest",  wb_dest, 0);
    chk("abort_zero",     zero_flag, 0);
    chk("abort_carry",    carry_flag, 0);
    chk("abort_busy",     busy, 0);
    chk("abort_ready",    in_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (wb_write) pulses++;
    end
    chk("abort_no_pulse", pulses, 0);
    chk("abort_ready_after", in_ready, 1);
    do_single("add_after_abort", 3'd0, 16'h0002, 16'h0003, 2'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
